// File: rtl/intc_pkg.sv
// Shared types and defaults for the multi-channel interrupt controller.
package intc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        SVC  = 2'd2
    } state_e;

    localparam logic [15:0] DEF_VEC_BASE   = 16'h0002;
    localparam int          DEF_VEC_STRIDE = 2;

    // Channel-id width; never below 1 so a port of that width stays legal.
    function automatic int idw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/intc_prio_enc.sv
// Lowest-index-wins priority encoder over a request vector.
module intc_prio_enc #(
    parameter int N   = 4,
    parameter int IDW = 2
) (
    input  logic [N-1:0]   req,
    output logic           valid,
    output logic [IDW-1:0] id
);

    // Scan from the top down so the lowest set index is the last one written.
    always_comb begin
        valid = 1'b0;
        id    = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                valid = 1'b1;
                id    = IDW'(i);
            end
        end
    end

endmodule

// File: rtl/intc_multi_irq.sv
// Edge-triggered, maskable, fixed-priority interrupt controller with an
// ack/eoi handshake and per-channel vector output.
module intc_multi_irq
    import intc_pkg::*;
#(
    parameter int             N_IRQ      = 4,
    parameter int             W          = 16,
    parameter logic [W-1:0]   VEC_BASE   = W'(DEF_VEC_BASE),
    parameter int             VEC_STRIDE = DEF_VEC_STRIDE,
    localparam int            IDW        = idw(N_IRQ)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_IRQ-1:0] irq_in,
    input  logic             mask_we,
    input  logic [N_IRQ-1:0] mask_wdata,
    input  logic             ack,
    input  logic             eoi,
    input  logic             ovr_clr,
    output logic             interrupt,
    output logic [IDW-1:0]   irq_id,
    output logic [W-1:0]     vector,
    output logic [N_IRQ-1:0] pending,
    output logic [N_IRQ-1:0] overrun,
    output logic             in_service
);

    state_e           state_q, state_d;
    logic [N_IRQ-1:0] irq_prev_q;
    logic [N_IRQ-1:0] pending_q, pending_d;
    logic [N_IRQ-1:0] overrun_q, overrun_d;
    logic [N_IRQ-1:0] mask_q, mask_d;
    logic [IDW-1:0]   irq_id_q, irq_id_d;
    logic [W-1:0]     vector_q, vector_d;
    logic [N_IRQ-1:0] edge_evt, ack_clr, cand;
    logic             win_vld;
    logic [IDW-1:0]   win_id;

    // A fresh edge always beats a same-cycle ack clear, and is then not an overrun.
    always_comb begin
        edge_evt = irq_in & ~irq_prev_q;
        ack_clr  = '0;
        if (state_q == REQ && ack) begin
            ack_clr[irq_id_q] = 1'b1;
        end
        pending_d = (pending_q & ~ack_clr) | edge_evt;
        overrun_d = (ovr_clr ? '0 : overrun_q) | (edge_evt & pending_q & ~ack_clr);
        mask_d    = mask_we ? mask_wdata : mask_q;
    end

    assign cand = pending_q & ~mask_q;

    intc_prio_enc #(
        .N   (N_IRQ),
        .IDW (IDW)
    ) u_prio (
        .req   (cand),
        .valid (win_vld),
        .id    (win_id)
    );

    // irq_id is only reloaded in IDLE: a pending request is never retracted.
    always_comb begin
        state_d  = state_q;
        irq_id_d = irq_id_q;
        case (state_q)
            IDLE: begin
                if (win_vld) begin
                    irq_id_d = win_id;
                    state_d  = REQ;
                end
            end
            REQ:     if (ack) state_d = SVC;
            SVC:     if (eoi) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        vector_d = VEC_BASE + W'(VEC_STRIDE) * W'(irq_id_d);
    end

    always_ff @(posedge clk) begin
        irq_prev_q <= irq_in;
        if (rst) begin
            state_q   <= IDLE;
            pending_q <= '0;
            overrun_q <= '0;
            mask_q    <= '1;
            irq_id_q  <= '0;
            vector_q  <= VEC_BASE;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            overrun_q <= overrun_d;
            mask_q    <= mask_d;
            irq_id_q  <= irq_id_d;
            vector_q  <= vector_d;
        end
    end

    assign interrupt  = (state_q == REQ);
    assign in_service = (state_q == SVC);
    assign irq_id     = irq_id_q;
    assign vector     = vector_q;
    assign pending    = pending_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_intc_multi_irq.sv
// Bench for intc_multi_irq: directed vector table followed by randomized
// traffic compared against a channel-level reference model.
module tb_intc_multi_irq;

    localparam int N = 4;
    localparam int W = 16;

    logic         clk;
    logic         rst;
    logic [N-1:0] irq_in;
    logic         mask_we;
    logic [N-1:0] mask_wdata;
    logic         ack;
    logic         eoi;
    logic         ovr_clr;
    logic         interrupt;
    logic [1:0]   irq_id;
    logic [W-1:0] vector;
    logic [N-1:0] pending;
    logic [N-1:0] overrun;
    logic         in_service;

    intc_multi_irq #(.N_IRQ(N), .W(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .irq_in     (irq_in),
        .mask_we    (mask_we),
        .mask_wdata (mask_wdata),
        .ack        (ack),
        .eoi        (eoi),
        .ovr_clr    (ovr_clr),
        .interrupt  (interrupt),
        .irq_id     (irq_id),
        .vector     (vector),
        .pending    (pending),
        .overrun    (overrun),
        .in_service (in_service)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [N-1:0] irq;
        logic         mwe;
        logic [N-1:0] mwd;
        logic         ack;
        logic         eoi;
        logic         oclr;
        logic         rst;
        logic         e_int;
        int           e_id;
        int           e_vec;
        logic [N-1:0] e_pend;
        logic [N-1:0] e_ovr;
        logic         e_isv;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic [N-1:0] irq, input logic mwe, input logic [N-1:0] mwd,
                       input logic a, input logic e, input logic oc, input logic r,
                       input logic ei, input int eid, input int ev,
                       input logic [N-1:0] ep, input logic [N-1:0] eo, input logic es);
        vec_t v;
        v.irq = irq; v.mwe = mwe; v.mwd = mwd; v.ack = a; v.eoi = e; v.oclr = oc; v.rst = r;
        v.e_int = ei; v.e_id = eid; v.e_vec = ev; v.e_pend = ep; v.e_ovr = eo; v.e_isv = es;
        tbl.push_back(v);
    endtask

    // Reference model: channel bit arrays plus a three-phase handshake.
    bit [N-1:0] m_prev, m_pend, m_ovr, m_mask;
    int         m_phase;   // 0 waiting, 1 requesting, 2 servicing
    int         m_id;

    task automatic model_step();
        bit [N-1:0] np, no, nm, ev;
        int nphase, nid;
        if (rst) begin
            m_prev = irq_in; m_pend = '0; m_ovr = '0; m_mask = '1; m_phase = 0; m_id = 0;
            return;
        end
        ev = irq_in & ~m_prev;
        nphase = m_phase; nid = m_id;
        for (int c = 0; c < N; c++) begin
            bit taken;
            taken = (m_phase == 1) && ack && (c == m_id);
            np[c] = ev[c] ? 1'b1 : (taken ? 1'b0 : m_pend[c]);
            no[c] = (ev[c] && m_pend[c] && !taken) ? 1'b1 : (ovr_clr ? 1'b0 : m_ovr[c]);
        end
        nm = mask_we ? mask_wdata : m_mask;
        if (m_phase == 0) begin
            for (int c = N - 1; c >= 0; c--)
                if (m_pend[c] && !m_mask[c]) begin nphase = 1; nid = c; end
        end else if (m_phase == 1) begin
            if (ack) nphase = 2;
        end else if (eoi) begin
            nphase = 0;
        end
        m_prev = irq_in; m_pend = np; m_ovr = no; m_mask = nm; m_phase = nphase; m_id = nid;
    endtask

    task automatic model_cmp(input int cyc);
        chk($sformatf("rnd%0d interrupt", cyc), int'(interrupt), int'(m_phase == 1));
        chk($sformatf("rnd%0d in_service", cyc), int'(in_service), int'(m_phase == 2));
        chk($sformatf("rnd%0d irq_id", cyc), int'(irq_id), m_id);
        chk($sformatf("rnd%0d vector", cyc), int'(vector), (2 + m_id * 2) & 16'hffff);
        chk($sformatf("rnd%0d pending", cyc), int'(pending), int'(m_pend));
        chk($sformatf("rnd%0d overrun", cyc), int'(overrun), int'(m_ovr));
    endtask

    initial begin
        rst = 1'b1; irq_in = '0; mask_we = 1'b0; mask_wdata = '0;
        ack = 1'b0; eoi = 1'b0; ovr_clr = 1'b0;

        //   irq    mwe mwd    ack eoi oc rst | int id vec pend   ovr    isv
        // reset, unmask, single request on channel 2
        add(4'b0000, 1, 4'b0000, 0, 0, 0, 1,  0, 0, 2, 4'b0000, 4'b0000, 0);
        add(4'b0000, 1, 4'b0000, 0, 0, 0, 0,  0, 0, 2, 4'b0000, 4'b0000, 0);
        add(4'b0100, 0, 4'b0000, 0, 0, 0, 0,  0, 0, 2, 4'b0100, 4'b0000, 0);
        add(4'b0000, 0, 4'b0000, 0, 0, 0, 0,  1, 2, 6, 4'b0100, 4'b0000, 0);
        add(4'b0000, 0, 4'b0000, 1, 0, 0, 0,  0, 2, 6, 4'b0000, 4'b0000, 1);
        add(4'b0000, 0, 4'b0000, 0, 0, 0, 0,  0, 2, 6, 4'b0000, 4'b0000, 1);
        add(4'b0000, 0, 4'b0000, 0, 1, 0, 0,  0, 2, 6, 4'b0000, 4'b0000, 0);
        // priority: channels 3 and 1 together
        add(4'b1010, 0, 4'b0000, 0, 0, 0, 0,  0, 2, 6, 4'b1010, 4'b0000, 0);
        add(4'b1010, 0, 4'b0000, 0, 0, 0, 0,  1, 1, 4, 4'b1010, 4'b0000, 0);
        add(4'b0000, 0, 4'b0000, 1, 0, 0, 0,  0, 1, 4, 4'b1000, 4'b0000, 1);
        add(4'b0000, 0, 4'b0000, 0, 1, 0, 0,  0, 1, 4, 4'b1000, 4'b0000, 0);
        add(4'b0000, 0, 4'b0000, 0, 0, 0, 0,  1, 3, 8, 4'b1000, 4'b0000, 0);
        add(4'b0000, 0, 4'b0000, 1, 0, 0, 0,  0, 3, 8, 4'b0000, 4'b0000, 1);
        add(4'b0000, 0, 4'b0000, 0, 1, 0, 0,  0, 3, 8, 4'b0000, 4'b0000, 0);
        // mask hold on channel 0, then release
        add(4'b0001, 1, 4'b0001, 0, 0, 0, 0,  0, 3, 8, 4'b0001, 4'b0000, 0);
        add(4'b0000, 0, 4'b0000, 0, 0, 0, 0,  0, 3, 8, 4'b0001, 4'b0000, 0);
        add(4'b0000, 0, 4'b0000, 0, 0, 0, 0,  0, 3, 8, 4'b0001, 4'b0000, 0);
        add(4'b0000, 1, 4'b0000, 0, 0, 0, 0,  0, 3, 8, 4'b0001, 4'b0000, 0);
        add(4'b0000, 0, 4'b0000, 0, 0, 0, 0,  1, 0, 2, 4'b0001, 4'b0000, 0);
        // spurious eoi in REQ, ack in SVC, ack in IDLE
        add(4'b0000, 0, 4'b0000, 0, 1, 0, 0,  1, 0, 2, 4'b0001, 4'b0000, 0);
        add(4'b0000, 0, 4'b0000, 1, 0, 0, 0,  0, 0, 2, 4'b0000, 4'b0000, 1);
        add(4'b0000, 0, 4'b0000, 1, 0, 0, 0,  0, 0, 2, 4'b0000, 4'b0000, 1);
        add(4'b0000, 0, 4'b0000, 0, 1, 0, 0,  0, 0, 2, 4'b0000, 4'b0000, 0);
        add(4'b0000, 0, 4'b0000, 1, 0, 0, 0,  0, 0, 2, 4'b0000, 4'b0000, 0);
        // overrun, ovr_clr, set-wins against ack and against ovr_clr
        add(4'b0010, 0, 4'b0000, 0, 0, 0, 0,  0, 0, 2, 4'b0010, 4'b0000, 0);
        add(4'b0000, 0, 4'b0000, 0, 0, 0, 0,  1, 1, 4, 4'b0010, 4'b0000, 0);
        add(4'b0010, 0, 4'b0000, 0, 0, 0, 0,  1, 1, 4, 4'b0010, 4'b0010, 0);
        add(4'b0000, 0, 4'b0000, 0, 0, 1, 0,  1, 1, 4, 4'b0010, 4'b0000, 0);
        add(4'b0010, 0, 4'b0000, 1, 0, 0, 0,  0, 1, 4, 4'b0010, 4'b0000, 1);
        add(4'b0000, 0, 4'b0000, 0, 1, 0, 0,  0, 1, 4, 4'b0010, 4'b0000, 0);
        add(4'b0000, 0, 4'b0000, 0, 0, 0, 0,  1, 1, 4, 4'b0010, 4'b0000, 0);
        add(4'b0010, 0, 4'b0000, 0, 0, 1, 0,  1, 1, 4, 4'b0010, 4'b0010, 0);
        add(4'b0000, 0, 4'b0000, 0, 0, 1, 0,  1, 1, 4, 4'b0010, 4'b0000, 0);
        add(4'b0000, 0, 4'b0000, 1, 0, 0, 0,  0, 1, 4, 4'b0000, 4'b0000, 1);
        // reset while servicing with irq_in[0] held high through and after it
        add(4'b0001, 0, 4'b0000, 0, 0, 0, 1,  0, 0, 2, 4'b0000, 4'b0000, 0);
        add(4'b0001, 1, 4'b0000, 0, 0, 0, 0,  0, 0, 2, 4'b0000, 4'b0000, 0);
        add(4'b0001, 0, 4'b0000, 0, 0, 0, 0,  0, 0, 2, 4'b0000, 4'b0000, 0);
        add(4'b0000, 0, 4'b0000, 0, 0, 0, 0,  0, 0, 2, 4'b0000, 4'b0000, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            irq_in = tbl[i].irq; mask_we = tbl[i].mwe; mask_wdata = tbl[i].mwd;
            ack = tbl[i].ack; eoi = tbl[i].eoi; ovr_clr = tbl[i].oclr; rst = tbl[i].rst;
            @(posedge clk); #1;
            chk($sformatf("vec%0d interrupt", i), int'(interrupt), int'(tbl[i].e_int));
            chk($sformatf("vec%0d irq_id", i), int'(irq_id), tbl[i].e_id);
            chk($sformatf("vec%0d vector", i), int'(vector), tbl[i].e_vec);
            chk($sformatf("vec%0d pending", i), int'(pending), int'(tbl[i].e_pend));
            chk($sformatf("vec%0d overrun", i), int'(overrun), int'(tbl[i].e_ovr));
            chk($sformatf("vec%0d in_service", i), int'(in_service), int'(tbl[i].e_isv));
        end

        // Randomized traffic; the first cycle resets both DUT and model.
        for (int cyc = 0; cyc < 3000; cyc++) begin
            rst        = (cyc == 0) || ($urandom_range(0, 299) == 0);
            irq_in     = N'($urandom);
            mask_we    = ($urandom_range(0, 15) == 0);
            mask_wdata = N'($urandom) & N'($urandom);
            ack        = ($urandom_range(0, 3) == 0);
            eoi        = ($urandom_range(0, 3) == 0);
            ovr_clr    = ($urandom_range(0, 19) == 0);
            model_step();
            @(posedge clk); #1;
            model_cmp(cyc);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
